// File: rtl/tt_scanner.sv
// Truth-table scanner: walks a 3-input decoder through all eight input codes
// in binary or Gray order, capturing f into an 8-bit table plus a minterm count.
module tt_scanner (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic       hold,
  input  logic       f_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [7:0] tt,
  output logic [3:0] ones,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state_r;
  logic [2:0] idx_r;
  logic       mode_q_r;
  logic [2:0] abc_r;
  logic [7:0] tt_r;
  logic [3:0] ones_r;
  logic       busy_r;
  logic       done_r;
  logic [2:0] code_s;
  logic [2:0] next_code_s;

  // Step index to decoder code; Gray order keeps one input toggling per step.
  function automatic logic [2:0] code_of(input logic [2:0] i, input logic m);
    logic [2:0] res;
    if (m) begin
      res = i ^ (i >> 1);
    end else begin
      res = i;
    end
    return res;
  endfunction

  // Current and upcoming code derived from the step index.
  always_comb begin
    code_s      = code_of(idx_r, mode_q_r);
    next_code_s = code_of(idx_r + 3'd1, mode_q_r);
  end

  // Scan sequencer; hold in DRIVE/SAMPLE freezes every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      idx_r    <= 3'd0;
      mode_q_r <= 1'b0;
      abc_r    <= 3'd0;
      tt_r     <= 8'h00;
      ones_r   <= 4'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r  <= DRIVE;
            idx_r    <= 3'd0;
            mode_q_r <= mode;
            abc_r    <= 3'd0;
            tt_r     <= 8'h00;
            ones_r   <= 4'd0;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        DRIVE: begin
          if (!hold) begin
            state_r <= SAMPLE;
          end else begin
            state_r <= DRIVE;
          end
        end
        SAMPLE: begin
          if (!hold) begin
            tt_r[code_s] <= f_in;
            ones_r       <= ones_r + {3'b000, f_in};
            if (idx_r == 3'd7) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              idx_r   <= idx_r + 3'd1;
              abc_r   <= next_code_s;
              state_r <= DRIVE;
            end
          end else begin
            state_r <= SAMPLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign a    = abc_r[2];
  assign b    = abc_r[1];
  assign c    = abc_r[0];
  assign tt   = tt_r;
  assign ones = ones_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_tt_scanner.sv
// Directed self-checking bench for tt_scanner with a behavioural decoder on f_in.
module tb_tt_scanner;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic       hold;
  logic       f_in;
  logic       a;
  logic       b;
  logic       c;
  logic [7:0] tt;
  logic [3:0] ones;
  logic       busy;
  logic       done;

  logic [7:0] dec_tt;
  logic       force_en;
  logic       force_val;
  logic [2:0] gray_tab [8];

  int checks;
  int errors;

  tt_scanner dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .hold  (hold),
    .f_in  (f_in),
    .a     (a),
    .b     (b),
    .c     (c),
    .tt    (tt),
    .ones  (ones),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder under test: f = dec_tt[{a,b,c}], unless overridden by the bench.
  assign f_in = force_en ? force_val : dec_tt[{a, b, c}];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full scan from start edge E0 to E16, checking code order and stability.
  task automatic scan(input logic m, input string tag);
    logic [2:0] exp_code;
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = 1'b0;
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    chk({tag, "_clr"}, {20'd0, ones, tt}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      exp_code = m ? gray_tab[k] : 3'(k);
      chk({tag, "_code"}, 32'({a, b, c}), 32'(exp_code));
      tick();
      chk({tag, "_settle"}, 32'({a, b, c}), 32'(exp_code));
      chk({tag, "_notdone"}, 32'(done), 32'd0);
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    gray_tab  = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    dec_tt    = 8'hCE;
    force_en  = 1'b0;
    force_val = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    hold      = 1'b0;
    rst_n     = 1'b0;
    #12;
    chk("rst_outs", {18'd0, a, b, c, busy, done, ones, tt}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_stays", 32'({busy, done}), 32'd0);

    // Binary scan.
    scan(1'b0, "bin");
    chk("bin_tt", 32'(tt), 32'hCE);
    chk("bin_ones", 32'(ones), 32'd5);

    // Gray scan.
    scan(1'b1, "gray");
    chk("gray_tt", 32'(tt), 32'hCE);
    chk("gray_ones", 32'(ones), 32'd5);

    // Hold for 3 cycles in step 4 SAMPLE with f_in toggling.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("hold_pre_code", 32'({a, b, c}), 32'd4);
    hold      = 1'b1;
    force_en  = 1'b1;
    force_val = 1'b1;
    tick();
    chk("hold_frozen", 32'({busy, a, b, c}), 32'h0C);
    force_val = 1'b0;
    tick();
    force_val = 1'b1;
    tick();
    chk("hold_frozen2", 32'({a, b, c}), 32'd4);
    hold     = 1'b0;
    force_en = 1'b0;
    repeat (6) tick();
    chk("hold_notdone_e18", 32'(done), 32'd0);
    tick();
    chk("hold_done_e19", 32'(done), 32'd1);
    chk("hold_tt", 32'(tt), 32'hCE);
    chk("hold_ones", 32'(ones), 32'd5);

    // Mid-scan start is ignored; start in DONE restarts and clears.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("midstart_code", 32'({busy, a, b, c}), 32'h0A);
    repeat (11) tick();
    chk("midstart_done", 32'(done), 32'd1);
    chk("midstart_tt", 32'(tt), 32'hCE);
    force_en  = 1'b1;
    force_val = 1'b1;
    scan(1'b0, "ones");
    chk("ones_tt", 32'(tt), 32'hFF);
    chk("ones_cnt", 32'(ones), 32'd8);
    force_en = 1'b0;

    // Async reset during step 3 DRIVE.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("rst_pre_code", 32'({a, b, c}), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {18'd0, a, b, c, busy, done, ones, tt}, 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("rst_after_idle", 32'({busy, done, tt}), 32'd0);
    scan(1'b1, "post_rst");
    chk("post_rst_tt", 32'(tt), 32'hCE);
    chk("post_rst_ones", 32'(ones), 32'd5);

    // f_in stuck low; done must persist until the next start.
    force_en  = 1'b1;
    force_val = 1'b0;
    scan(1'b0, "zero");
    chk("zero_tt", 32'(tt), 32'h00);
    chk("zero_ones", 32'(ones), 32'd0);
    hold = 1'b1;
    repeat (5) tick();
    hold = 1'b0;
    chk("zero_done_held", 32'({busy, done}), 32'd1);
    force_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
